// File: rtl/mem_mesh_array.sv
// Banked shared-memory fabric: per-core banks with spread (broadcast) writes and an I/O window.
// Define MEM_MESH_RESET_CLEAR_EN to have reset clear every bank word; otherwise banks are RAM-like.
module mem_mesh_array #(
    parameter int CORES         = 8,
    parameter int DEPTH         = 256,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int SPREAD_LAYERS = 3,
    parameter int SPREAD_WIDTH  = 3,
    parameter int USE_IO        = 1,
    parameter int IO_PORTS      = 16,
    parameter int IO_FIRST      = 5
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [CORES-1:0]               i_we,
    input  logic [CORES*ADDR_WIDTH-1:0]    i_waddr,
    input  logic [CORES*SPREAD_WIDTH-1:0]  i_wspread,
    input  logic [CORES*DATA_WIDTH-1:0]    i_wdata,
    input  logic [CORES*ADDR_WIDTH-1:0]    i_raddr,
    output logic [CORES*DATA_WIDTH-1:0]    o_rdata,
    input  logic [IO_PORTS-1:0]            i_io_active_in,
    output logic [IO_PORTS-1:0]            o_io_active_out,
    input  logic [IO_PORTS*DATA_WIDTH-1:0] i_io_data_in,
    output logic [IO_PORTS*DATA_WIDTH-1:0] o_io_data_out
);

    logic [DATA_WIDTH-1:0]   r_mem [CORES][DEPTH];
    logic [IO_PORTS-1:0]     r_io_act;
    logic [DATA_WIDTH-1:0]   r_io_data [IO_PORTS];

    logic [ADDR_WIDTH-1:0]   w_waddr   [CORES];
    logic [SPREAD_WIDTH-1:0] w_wspread [CORES];
    logic [DATA_WIDTH-1:0]   w_wdata   [CORES];
    logic [ADDR_WIDTH-1:0]   w_raddr   [CORES];
    logic [CORES-1:0]        w_waddr_ok;
    logic [DATA_WIDTH-1:0]   w_io_data_in [IO_PORTS];
    logic [IO_PORTS-1:0]     w_io_in_en;
    logic [IO_PORTS-1:0]     w_io_act_d;
    logic [DATA_WIDTH-1:0]   w_io_data_d [IO_PORTS];

    for (genvar c = 0; c < CORES; c++) begin : g_unpack
        assign w_waddr[c]    = i_waddr[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wspread[c]  = i_wspread[c*SPREAD_WIDTH +: SPREAD_WIDTH];
        assign w_wdata[c]    = i_wdata[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_raddr[c]    = i_raddr[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_waddr_ok[c] = 32'(w_waddr[c]) < 32'(DEPTH);
    end

    for (genvar p = 0; p < IO_PORTS; p++) begin : g_io_unpack
        assign w_io_data_in[p] = i_io_data_in[p*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_io_in_en = (USE_IO != 0) ? i_io_active_in : '0;

    // Bank b is a target of writer c with code s: own bank, aligned 2^s group, or all.
    function automatic logic f_hit(input int b, input int c, input int s);
        if (s == 0) begin
            return b == c;
        end else if (s <= SPREAD_LAYERS) begin
            return (b >> s) == (c >> s);
        end else begin
            return 1'b1;
        end
    endfunction

    // Later assignments win: cores iterate high-to-low so the lowest core wins, then I/O overrides.
`ifdef MEM_MESH_RESET_CLEAR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < CORES; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    r_mem[b][a] <= '0;
                end
            end
        end else begin
`else
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
`endif
            for (int b = 0; b < CORES; b++) begin
                for (int c = CORES - 1; c >= 0; c--) begin
                    if (i_we[c] && w_waddr_ok[c] && f_hit(b, c, int'(w_wspread[c]))) begin
                        r_mem[b][w_waddr[c]] <= w_wdata[c];
                    end
                end
                for (int p = 0; p < IO_PORTS; p++) begin
                    if (w_io_in_en[p]) begin
                        r_mem[b][IO_FIRST + p] <= w_io_data_in[p];
                    end
                end
            end
        end
    end

    always_comb begin
        w_io_act_d = '0;
        for (int p = 0; p < IO_PORTS; p++) begin
            w_io_data_d[p] = r_io_data[p];
        end
        if (USE_IO != 0) begin
            for (int p = 0; p < IO_PORTS; p++) begin
                for (int c = CORES - 1; c >= 0; c--) begin
                    if (i_we[c] && (32'(w_waddr[c]) == 32'(IO_FIRST + p))) begin
                        w_io_act_d[p]  = 1'b1;
                        w_io_data_d[p] = w_wdata[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_io_act <= '0;
            for (int p = 0; p < IO_PORTS; p++) begin
                r_io_data[p] <= '0;
            end
        end else begin
            r_io_act <= w_io_act_d;
            for (int p = 0; p < IO_PORTS; p++) begin
                r_io_data[p] <= w_io_data_d[p];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int c = 0; c < CORES; c++) begin
            if (32'(w_raddr[c]) < 32'(DEPTH)) begin
                o_rdata[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][w_raddr[c]];
            end
        end
    end

    if (USE_IO != 0) begin : g_io_out
        assign o_io_active_out = r_io_act;
        for (genvar p = 0; p < IO_PORTS; p++) begin : g_pack
            assign o_io_data_out[p*DATA_WIDTH +: DATA_WIDTH] = r_io_data[p];
        end
    end else begin : g_io_off
        assign o_io_active_out = '0;
        assign o_io_data_out   = '0;
    end

endmodule

// File: tb/tb_mem_mesh_array.sv
// Directed bench for mem_mesh_array: expectations queued per step, compared one cycle later.
module tb_mem_mesh_array;

    localparam int CORES = 8;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int SW    = 3;
    localparam int NP    = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CORES-1:0]     we;
    logic [CORES*AW-1:0]  waddr;
    logic [CORES*SW-1:0]  wspread;
    logic [CORES*DW-1:0]  wdata;
    logic [CORES*AW-1:0]  raddr;
    logic [CORES*DW-1:0]  rdata;
    logic [NP-1:0]        io_active_in;
    logic [NP-1:0]        io_active_out;
    logic [NP*DW-1:0]     io_data_in;
    logic [NP*DW-1:0]     io_data_out;

    mem_mesh_array dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_we            (we),
        .i_waddr         (waddr),
        .i_wspread       (wspread),
        .i_wdata         (wdata),
        .i_raddr         (raddr),
        .o_rdata         (rdata),
        .i_io_active_in  (io_active_in),
        .o_io_active_out (io_active_out),
        .i_io_data_in    (io_data_in),
        .o_io_data_out   (io_data_out)
    );

    always #5 clk = ~clk;

    // kind: 0 rdata[idx], 1 io_active_out[idx], 2 io_data_out[idx], 3 whole io_active_out
    typedef struct {
        int          kind;
        int          idx;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    function automatic logic [15:0] f_obs(input int kind, input int idx);
        case (kind)
            0:       return rdata[idx*DW +: DW];
            1:       return {15'b0, io_active_out[idx]};
            2:       return io_data_out[idx*DW +: DW];
            default: return io_active_out;
        endcase
    endfunction

    task automatic push(input int kind, input int idx, input logic [15:0] e, input string tag);
        exp_t x;
        x.kind = kind;
        x.idx  = idx;
        x.exp  = e;
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t        x;
        logic [15:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = f_obs(x.kind, x.idx);
            n_total++;
            assert (o === x.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s[%0d]: got %h expected %h", x.tag, x.idx, o, x.exp);
            end
        end
    endtask

    task automatic idle();
        we           = '0;
        io_active_in = '0;
    endtask

    task automatic wr(input int c, input int a, input int s, input logic [15:0] d);
        we[c]                 = 1'b1;
        waddr[c*AW +: AW]     = AW'(a);
        wspread[c*SW +: SW]   = SW'(s);
        wdata[c*DW +: DW]     = d;
    endtask

    task automatic set_raddr_all(input int a);
        for (int c = 0; c < CORES; c++) raddr[c*AW +: AW] = AW'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vals [5];
        logic [15:0] exp_keep;
        vals = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
        rst = 1'b1;
        we = '0; waddr = '0; wspread = '0; wdata = '0;
        io_active_in = '0; io_data_in = '0;
        set_raddr_all(8);
        raddr[7*AW +: AW] = 8'd192;

        repeat (2) @(posedge clk);
        #1;
        push(3, 0, 16'h0, "rst_io_act");
        for (int p = 0; p < NP; p++) push(2, p, 16'h0, "rst_io_data");
        check_all();
        rst = 1'b0;

        // Known-zero contents at the addresses under test
        idle(); wr(0, 8, 7, 16'h0);   step();
        idle(); wr(0, 192, 7, 16'h0); step();
        idle(); wr(0, 40, 7, 16'h0);  step();
        idle();
        push(0, 2, 16'h0, "init_b2"); push(0, 3, 16'h0, "init_b3");
        push(0, 6, 16'h0, "init_b6"); push(0, 7, 16'h0, "init_b7_192");
        push(3, 0, 16'h0, "idle_io_act");
        step(); check_all();

        // Core 2 spreads to address 8 with codes 0..4
        for (int s = 0; s <= 4; s++) begin
            idle(); wr(2, 8, s, vals[s]);
            push(0, 2, vals[s], "spread_b2");
            push(0, 3, (s >= 1) ? vals[s] : 16'h0, "spread_b3");
            push(0, 6, (s >= 3) ? vals[s] : 16'h0, "spread_b6");
            push(0, 0, (s >= 2) ? vals[s] : 16'h0, "spread_b0");
            push(0, 7, 16'h0, "spread_b7_192");
            push(1, 3, 16'h1, "spread_io_act");
            push(2, 3, vals[s], "spread_io_data");
            step(); check_all();
        end
        idle();
        push(3, 0, 16'h0, "strobe_drop");
        push(2, 3, 16'd500, "io_data_hold");
        step(); check_all();

        // Incoming I/O write beats a same-cycle core write
        wr(2, 8, 7, 16'd777);
        io_active_in[3] = 1'b1;
        io_data_in[3*DW +: DW] = 16'd1234;
        for (int c = 0; c < 7; c++) push(0, c, 16'd1234, "io_in_override");
        push(1, 3, 16'h1, "io_in_core_strobe");
        push(2, 3, 16'd777, "io_in_core_data");
        step(); check_all();
        idle();
        push(3, 0, 16'h0, "io_in_strobe_drop");
        step(); check_all();

        // Collision: cores 1 and 5 broadcast to address 40
        set_raddr_all(40);
        wr(1, 40, 3, 16'h1111); wr(5, 40, 3, 16'h5555);
        push(0, 0, 16'h1111, "collide_b0"); push(0, 5, 16'h1111, "collide_b5");
        push(0, 7, 16'h1111, "collide_b7"); push(3, 0, 16'h0, "collide_no_io");
        step(); check_all();

        // Port collision on address 6 (port 1): own-bank writes, lowest core drives the port
        idle(); set_raddr_all(6);
        wr(1, 6, 0, 16'hAAAA); wr(5, 6, 0, 16'hBBBB);
        push(0, 1, 16'hAAAA, "port_b1"); push(0, 5, 16'hBBBB, "port_b5");
        push(1, 1, 16'h1, "port_act"); push(2, 1, 16'hAAAA, "port_data");
        step(); check_all();

        // Asynchronous reset mid-cycle; a write held during reset must be dropped
        idle(); wr(0, 40, 7, 16'h9999);
        #2 rst = 1'b1;
        #1;
        push(3, 0, 16'h0, "async_rst_act");
        push(2, 1, 16'h0, "async_rst_data");
        check_all();
        step();
        idle(); rst = 1'b0; set_raddr_all(40);
`ifdef MEM_MESH_RESET_CLEAR_EN
        exp_keep = 16'h0;
`else
        exp_keep = 16'h1111;
`endif
        #1;
        push(0, 0, exp_keep, "rst_write_drop_b0");
        push(0, 6, exp_keep, "rst_write_drop_b6");
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
